pe_array_seq: RTL and testbench
===============================

PE_ARRAY_SEQ -- requirements
Module: pe_array_seq

Interface
REQ-001 Parameter WIDTH_WGT, default 8, signed weight width per lane.
REQ-002 Parameter DATA_WIDTH, default 8, activation width.
REQ-003 Parameter PSUM_WIDTH, default 32, accumulator and output width.
REQ-004 Parameter N_PEs, default 16, lane count (≥2).
REQ-005 Parameter BIAS_WIDTH, default 16, signed bias width per lane.
REQ-006 Parameter KW, default 10, width of the accumulation-length field.
REQ-007 The block SHALL use one clock; reset is synchronous and active-high; ports are clk and reset.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 start  in  1  begin a job; accepted only in IDLE.
REQ-011 k_len  in  KW  number of activation beats per job; sampled with start.
REQ-012 if_relu, ia_sign  in  1 each  ReLU enable and signed-activation mode; sampled with start.
REQ-013 bias  in  BIAS_WIDTH*N_PEs  lane biases; lane i is bits [BIAS_WIDTH*(N_PEs-i)-1 : BIAS_WIDTH*(N_PEs-i-1)]; sampled with start.
REQ-014 ia_valid / ia_ready  in / out  1  activation handshake.
REQ-015 ia  in  DATA_WIDTH  activation, broadcast to all lanes.
REQ-016 wgt  in  WIDTH_WGT*N_PEs  per-beat weights; lane slicing follows the bias rule; sampled with ia.
REQ-017 psum_valid / psum_ready  out / in  1  result handshake.
REQ-018 psum_out  out  PSUM_WIDTH  serialised lane result.
REQ-019 psum_last  out  1  marks the final result beat.
REQ-020 busy  out  1  high in any state other than IDLE.
REQ-021 done  out  1  one-cycle pulse after the last result handshake.

Function
REQ-022 The FSM SHALL have states IDLE, ACCUM and DRAIN.
REQ-023 In IDLE, a start pulse SHALL load every accumulator with its sign-extended bias and latch k_len, if_relu and ia_sign.
REQ-024 On the start edge, the FSM SHALL move to ACCUM if k_len≠0, or to DRAIN if k_len=0.
REQ-025 In ACCUM, ia_ready SHALL be 1; each ia_valid&&ia_ready beat SHALL perform acc[i] += ext(ia)*wgt[i] for every lane i.
REQ-026 ext(ia) SHALL be the signed value when ia_sign=1 and the zero-extended value otherwise; the product SHALL be sign-extended to PSUM_WIDTH.
REQ-027 Accumulation SHALL wrap modulo 2^PSUM_WIDTH, with no saturation.
REQ-028 After the k_len-th beat, the FSM SHALL move to DRAIN on the next edge, and ia_ready SHALL drop to 0 in that same edge.
REQ-029 In DRAIN, psum_valid SHALL be 1 and results SHALL be presented in lane order N_PEs-1 down to 0; a handshake advances to the next lane.
REQ-030 When if_relu=1, a negative result SHALL be output as 0; accumulator contents SHALL not be modified by ReLU.
REQ-031 While psum_valid=1 and psum_ready=0, psum_out and psum_last SHALL hold stable.
REQ-032 psum_last SHALL be 1 only with lane 0; its handshake SHALL return the FSM to IDLE and pulse done in the following cycle.
REQ-033 start SHALL be ignored while busy=1; ia_ready SHALL be 0 outside ACCUM; psum_valid SHALL be 0 outside DRAIN.

Reset
REQ-034 Reset SHALL force IDLE, all accumulators to 0, and drain and beat counters to 0, at any point including mid-ACCUM or mid-DRAIN.
REQ-035 Output reset values SHALL be: ia_ready=0, psum_valid=0, psum_out=0, psum_last=0, busy=0, done=0.
REQ-036 Reset SHALL take priority over start on the same edge.

Structure
REQ-037 The FSM state encoding and the lane-slice helper SHALL live in a shared package, pe_array_pkg.
REQ-038 One sub-module, pe_mac (per-lane accumulator with bias load), SHALL be instantiated N_PEs times by generate; the FSM, counters and drain mux SHALL reside in pe_array_seq.

Verification (N_PEs=4, PSUM_WIDTH=32 unless stated)
REQ-039 Basic job: bias=0, k_len=2, ia_sign=1, ia 3 then 2, wgt lanes {1,2,3,-1} both beats -> results -5, 15, 10, 5 with psum_last on 5, then done.
REQ-040 ReLU: same job with if_relu=1 -> results 0, 15, 10, 5.
REQ-041 Unsigned activation: ia_sign=0, ia=8'hFF, all wgt=2, k_len=1, bias=-10 -> every lane outputs 500.
REQ-042 k_len=0 with bias lanes {7,-3,0,1} -> DRAIN immediately with results 1, 0, -3, 7 and no ia_ready assertion.
REQ-043 Backpressure and ignored start: psum_ready low for 5 cycles mid-drain -> output held; a start during DRAIN is ignored; ia_valid gaps in ACCUM do not change results.
REQ-044 Wrap and reset: PSUM_WIDTH=8 with 127+1 accumulation -> -128; reset asserted mid-ACCUM -> IDLE next cycle with all outputs at reset values.

Source files
------------

// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array: FSM state encoding and the lane-slice helper.
// Lane 0 occupies the most-significant slice of every packed per-lane bus.
package pe_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // LSB position of lane 'lane' inside a packed bus of n_lanes slices of 'width' bits.
  function automatic int lane_lsb(input int lane, input int width, input int n_lanes);
    return width * (n_lanes - lane - 1);
  endfunction

endpackage

// File: rtl/pe_array_seq_mac.sv
// Per-lane multiply-accumulate: loads the sign-extended bias on start, then adds
// ext(ia)*wgt on each accepted beat, wrapping modulo 2^PSUM_WIDTH.
module pe_mac #(
  parameter int WIDTH_WGT  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int BIAS_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  acc_en,
  input  logic                  ia_sign,
  input  logic [BIAS_WIDTH-1:0] bias,
  input  logic [DATA_WIDTH-1:0] ia,
  input  logic [WIDTH_WGT-1:0]  wgt,
  output logic [PSUM_WIDTH-1:0] acc
);

  localparam int PW = DATA_WIDTH + 1 + WIDTH_WGT;
  localparam int EW = (PW > PSUM_WIDTH) ? PW : PSUM_WIDTH;
  localparam int BW = (BIAS_WIDTH > PSUM_WIDTH) ? BIAS_WIDTH : PSUM_WIDTH;

  logic signed [DATA_WIDTH:0] w_ia_ext;
  logic signed [PW-1:0]       w_prod;
  logic signed [EW-1:0]       w_prod_ext;
  logic signed [BW-1:0]       w_bias_ext;
  logic [PSUM_WIDTH-1:0]      r_acc;

  // One extra bit lets the same signed multiplier serve both activation modes.
  assign w_ia_ext   = {ia_sign & ia[DATA_WIDTH-1], ia};
  assign w_prod     = PW'(w_ia_ext) * PW'($signed(wgt));
  assign w_prod_ext = EW'(w_prod);
  assign w_bias_ext = BW'($signed(bias));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (load) begin
      r_acc <= w_bias_ext[PSUM_WIDTH-1:0];
    end else if (acc_en) begin
      r_acc <= r_acc + w_prod_ext[PSUM_WIDTH-1:0];
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/pe_array_seq.sv
// Sequential PE array: N_PEs lanes accumulate a broadcast activation stream against
// per-lane weights, then serialise results lane N_PEs-1 down to 0 with optional ReLU.
module pe_array_seq
  import pe_array_pkg::*;
#(
  parameter int WIDTH_WGT  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int N_PEs      = 16,
  parameter int BIAS_WIDTH = 16,
  parameter int KW         = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [KW-1:0]               k_len,
  input  logic                        if_relu,
  input  logic                        ia_sign,
  input  logic [BIAS_WIDTH*N_PEs-1:0] bias,
  input  logic                        ia_valid,
  output logic                        ia_ready,
  input  logic [DATA_WIDTH-1:0]       ia,
  input  logic [WIDTH_WGT*N_PEs-1:0]  wgt,
  output logic                        psum_valid,
  input  logic                        psum_ready,
  output logic [PSUM_WIDTH-1:0]       psum_out,
  output logic                        psum_last,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  dbg_state
);

  localparam int LW = $clog2(N_PEs);

  // Handshakes: a transfer happens on a rising edge where valid && ready; ia_ready is
  // high exactly in ACCUM, psum_valid exactly in DRAIN, both derived from state only.
  state_t                r_state, w_next;
  logic [KW-1:0]         r_k_len, r_beat;
  logic [LW-1:0]         r_lane;
  logic                  r_relu, r_sign, r_done;
  logic                  w_start, w_beat, w_last_beat, w_out_hs;
  logic [PSUM_WIDTH-1:0] w_acc [N_PEs];
  logic [PSUM_WIDTH-1:0] w_sel;

  assign w_start     = (r_state == ST_IDLE) && start;
  assign w_beat      = (r_state == ST_ACCUM) && ia_valid;
  assign w_last_beat = w_beat && (r_beat == r_k_len - KW'(1));
  assign w_out_hs    = (r_state == ST_DRAIN) && psum_ready;
  assign w_sel       = w_acc[r_lane];

  always_comb begin
    w_next     = r_state;
    ia_ready   = 1'b0;
    psum_valid = 1'b0;
    psum_last  = 1'b0;
    psum_out   = '0;
    busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:  if (start) w_next = (k_len == '0) ? ST_DRAIN : ST_ACCUM;
      ST_ACCUM: begin
        ia_ready = 1'b1;
        if (w_last_beat) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        psum_valid = 1'b1;
        psum_last  = (r_lane == '0);
        psum_out   = (r_relu && w_sel[PSUM_WIDTH-1]) ? '0 : w_sel;
        if (w_out_hs && r_lane == '0) w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_k_len <= '0;
      r_beat  <= '0;
      r_lane  <= '0;
      r_relu  <= 1'b0;
      r_sign  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_out_hs && (r_lane == '0);
      if (w_start) begin
        r_k_len <= k_len;
        r_relu  <= if_relu;
        r_sign  <= ia_sign;
        r_beat  <= '0;
        r_lane  <= LW'(N_PEs - 1);
      end
      if (w_beat)   r_beat <= r_beat + KW'(1);
      if (w_out_hs) r_lane <= r_lane - LW'(1);
    end
  end

  assign done      = r_done;
  assign dbg_state = r_state;

  for (genvar g = 0; g < N_PEs; g++) begin : g_lane
    pe_mac #(
      .WIDTH_WGT (WIDTH_WGT),
      .DATA_WIDTH(DATA_WIDTH),
      .PSUM_WIDTH(PSUM_WIDTH),
      .BIAS_WIDTH(BIAS_WIDTH)
    ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .load   (w_start),
      .acc_en (w_beat),
      .ia_sign(r_sign),
      .bias   (bias[lane_lsb(g, BIAS_WIDTH, N_PEs) +: BIAS_WIDTH]),
      .ia     (ia),
      .wgt    (wgt[lane_lsb(g, WIDTH_WGT, N_PEs) +: WIDTH_WGT]),
      .acc    (w_acc[g])
    );
  end

endmodule

// File: tb/tb_pe_array_seq.sv
// Bench for pe_array_seq with 4 lanes: a 32-bit accumulator instance and an 8-bit one
// sharing the same stimulus; 'sel8' picks which instance's outputs are checked.
module tb_pe_array_seq;

  localparam int N = 4;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic        if_relu = 1'b0, ia_sign = 1'b0, ia_valid = 1'b0, psum_ready = 1'b0;
  logic [9:0]  k_len = '0;
  logic [63:0] bias = '0;
  logic [7:0]  ia = '0;
  logic [31:0] wgt = '0;
  logic        sel8 = 1'b0;

  logic        ia_ready_a, psum_valid_a, psum_last_a, busy_a, done_a;
  logic [31:0] psum_out_a;
  logic [1:0]  dbg_a;
  logic        ia_ready_b, psum_valid_b, psum_last_b, busy_b, done_b;
  logic [7:0]  psum_out_b;
  logic [1:0]  dbg_b;

  logic        m_ready, m_valid, m_last, m_busy, m_done;
  logic [31:0] m_out;
  logic [1:0]  m_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pe_array_seq #(.N_PEs(N), .PSUM_WIDTH(32)) dut_a (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .if_relu(if_relu),
    .ia_sign(ia_sign), .bias(bias), .ia_valid(ia_valid), .ia_ready(ia_ready_a),
    .ia(ia), .wgt(wgt), .psum_valid(psum_valid_a), .psum_ready(psum_ready),
    .psum_out(psum_out_a), .psum_last(psum_last_a), .busy(busy_a), .done(done_a),
    .dbg_state(dbg_a)
  );

  pe_array_seq #(.N_PEs(N), .PSUM_WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .if_relu(if_relu),
    .ia_sign(ia_sign), .bias(bias), .ia_valid(ia_valid), .ia_ready(ia_ready_b),
    .ia(ia), .wgt(wgt), .psum_valid(psum_valid_b), .psum_ready(psum_ready),
    .psum_out(psum_out_b), .psum_last(psum_last_b), .busy(busy_b), .done(done_b),
    .dbg_state(dbg_b)
  );

  assign m_ready = sel8 ? ia_ready_b   : ia_ready_a;
  assign m_valid = sel8 ? psum_valid_b : psum_valid_a;
  assign m_last  = sel8 ? psum_last_b  : psum_last_a;
  assign m_busy  = sel8 ? busy_b       : busy_a;
  assign m_done  = sel8 ? done_b       : done_a;
  assign m_dbg   = sel8 ? dbg_b        : dbg_a;
  assign m_out   = sel8 ? {{24{psum_out_b[7]}}, psum_out_b} : psum_out_a;

  typedef struct {
    logic [9:0]       k_len;
    logic             relu;
    logic             sign;
    logic [63:0]      bias;
    logic [7:0]       ia0;
    logic [7:0]       ia1;
    logic [31:0]      wgt;
    logic [3:0][31:0] exp;   // exp[0] is the first drained result (lane 3)
  } job_t;

  job_t jobs [6];
  job_t hj;

  function automatic job_t mk(input logic [9:0] k, input logic r, input logic s,
                              input logic [63:0] b, input logic [7:0] a0, input logic [7:0] a1,
                              input logic [31:0] w, input int e0, input int e1,
                              input int e2, input int e3);
    job_t j;
    j.k_len = k; j.relu = r; j.sign = s; j.bias = b;
    j.ia0 = a0; j.ia1 = a1; j.wgt = w;
    j.exp[0] = e0; j.exp[1] = e1; j.exp[2] = e2; j.exp[3] = e3;
    return j;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ia_ready"},   m_ready, 0);
    chk({tag, "_psum_valid"}, m_valid, 0);
    chk({tag, "_psum_out"},   m_out,   0);
    chk({tag, "_psum_last"},  m_last,  0);
    chk({tag, "_busy"},       m_busy,  0);
    chk({tag, "_done"},       m_done,  0);
    chk({tag, "_state"},      m_dbg,   0);
  endtask

  // Runs one job; gap inserts idle ia_valid cycles before each beat, bp_lane stalls
  // psum_ready for 5 cycles at that drain position while a stray start is driven.
  task automatic run_job(input job_t j, input int gap, input int bp_lane, input string tag);
    int n;
    start = 1'b1; k_len = j.k_len; if_relu = j.relu; ia_sign = j.sign; bias = j.bias;
    psum_ready = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < int'(j.k_len); b++) begin
      if (gap > 0) begin
        ia_valid = 1'b0; ia = 8'h55; wgt = 32'h7F7F7F7F;
        repeat (gap) step();
      end
      ia_valid = 1'b1; ia = (b == 0) ? j.ia0 : j.ia1; wgt = j.wgt;
      n = 0;
      while (!m_ready && n < 20) begin step(); n++; end
      chk($sformatf("%s_ia_ready_b%0d", tag, b), m_ready, 1);
      step();
    end
    ia_valid = 1'b0;
    chk($sformatf("%s_ia_ready_drain", tag), m_ready, 0);
    for (int l = 0; l < N; l++) begin
      n = 0;
      while (!m_valid && n < 20) begin step(); n++; end
      chk($sformatf("%s_valid%0d", tag, l), m_valid, 1);
      if (l == bp_lane) begin
        psum_ready = 1'b0; start = 1'b1; k_len = 10'd1; bias = '1;
        repeat (5) begin
          step();
          chk($sformatf("%s_hold_out%0d", tag, l), m_out, j.exp[l]);
          chk($sformatf("%s_hold_last%0d", tag, l), m_last, (l == N - 1) ? 1 : 0);
        end
        start = 1'b0; bias = j.bias; psum_ready = 1'b1;
      end
      chk($sformatf("%s_out%0d", tag, l), m_out, j.exp[l]);
      chk($sformatf("%s_last%0d", tag, l), m_last, (l == N - 1) ? 1 : 0);
      step();
    end
    chk($sformatf("%s_done", tag), m_done, 1);
    chk($sformatf("%s_busy_idle", tag), m_busy, 0);
    step();
    chk($sformatf("%s_done_pulse", tag), m_done, 0);
    psum_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    jobs[0] = mk(10'd2, 1'b0, 1'b1, 64'h0, 8'd3, 8'd2, {8'd1, 8'd2, 8'd3, 8'hFF}, -5, 15, 10, 5);
    jobs[1] = mk(10'd2, 1'b1, 1'b1, 64'h0, 8'd3, 8'd2, {8'd1, 8'd2, 8'd3, 8'hFF}, 0, 15, 10, 5);
    jobs[2] = mk(10'd1, 1'b0, 1'b0, {4{16'hFFF6}}, 8'hFF, 8'h00, {4{8'd2}}, 500, 500, 500, 500);
    jobs[3] = mk(10'd0, 1'b0, 1'b1, {16'd7, 16'hFFFD, 16'd0, 16'd1}, 8'h00, 8'h00, 32'h0,
                 1, 0, -3, 7);
    jobs[4] = mk(10'd1, 1'b0, 1'b1, {16'd100, 16'd0, 16'd0, 16'hFFFF}, 8'hFE, 8'h00,
                 {8'd4, 8'hFC, 8'd0, 8'd127}, -255, 0, 8, 92);
    jobs[5] = mk(10'd1, 1'b0, 1'b0, {16'd100, 16'd0, 16'd0, 16'hFFFF}, 8'hFE, 8'h00,
                 {8'd4, 8'hFC, 8'd0, 8'd127}, 32257, 0, -1016, 1116);

    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_job(jobs[i], 0, -1, $sformatf("job%0d", i));

    run_job(jobs[0], 2, 1, "bp_gap");

    sel8 = 1'b1;
    hj = mk(10'd2, 1'b0, 1'b1, 64'h0, 8'd127, 8'd1, {4{8'd1}}, -128, -128, -128, -128);
    run_job(hj, 0, -1, "wrap8");
    sel8 = 1'b0;

    start = 1'b1; k_len = 10'd3; if_relu = 1'b0; ia_sign = 1'b1; bias = '0;
    step();
    start = 1'b0; ia_valid = 1'b1; ia = 8'd5; wgt = {4{8'd1}};
    step();
    chk("mid_accum_busy", m_busy, 1);
    reset = 1'b1; ia_valid = 1'b0;
    step();
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    run_job(jobs[4], 0, -1, "after_reset");

    reset = 1'b1; start = 1'b1; k_len = 10'd1;
    step();
    reset = 1'b0; start = 1'b0;
    chk("rst_vs_start_busy", m_busy, 0);
    chk("rst_vs_start_state", m_dbg, 0);
    step();
    chk("rst_vs_start_busy2", m_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
